fpu_round_pack: RTL and testbench

Pipelined round-and-pack stage that consumes the normalized result of the FPU square-root normalize step and produces the final IEEE-754 single-precision word plus exception flags. It applies the requested rounding mode to the 24-bit mantissa and 3 guard bits, handles mantissa carry-out, overflow, subnormal and special-value packing, and exposes valid/ready handshakes on both sides. It sits directly between the sqrt normalize step and the FPU result writeback.

---
 rtl/fpu_round_pack.sv | 177 +++++++++++++++++
 tb/tb_fpu_round_pack.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_round_pack.sv
// fpu_round_pack: round-and-pack stage for single-precision results.
// Two-stage valid/ready pipeline: S1 decides rounding, S2 packs and flags.
module fpu_round_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exponent,
    input  logic [23:0] in_mantissa,
    input  logic [2:0]  in_guard,
    input  logic        in_nan,
    input  logic        in_inf,
    input  logic        in_zero,
    input  logic [2:0]  in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags
);

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q, s1_sign_d;
    logic [7:0]  s1_exp_q, s1_exp_d;
    logic [24:0] s1_sum_q, s1_sum_d;
    logic        s1_inexact_q, s1_inexact_d;
    logic        s1_nan_q, s1_nan_d;
    logic        s1_inf_q, s1_inf_d;
    logic        s1_zero_q, s1_zero_d;
    logic [2:0]  s1_mode_q, s1_mode_d;

    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_result_q, s2_result_d;
    logic [4:0]  s2_flags_q, s2_flags_d;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv     = !s2_valid_q || out_ready;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_flags  = s2_flags_q;

    // S1: decide the round-up increment and capture the incoming beat
    always_comb begin
        logic inexact;
        logic g;
        logic rs;
        logic lsb;
        logic up;
        inexact = |in_guard;
        g       = in_guard[2];
        rs      = |in_guard[1:0];
        lsb     = in_mantissa[0];
        unique case (in_mode)
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = inexact && in_sign;
            RM_RUP:  up = inexact && !in_sign;
            RM_RMM:  up = g;
            default: up = g && (rs || lsb);
        endcase

        s1_valid_d   = s1_adv ? in_valid : s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_exp_d     = s1_exp_q;
        s1_sum_d     = s1_sum_q;
        s1_inexact_d = s1_inexact_q;
        s1_nan_d     = s1_nan_q;
        s1_inf_d     = s1_inf_q;
        s1_zero_d    = s1_zero_q;
        s1_mode_d    = s1_mode_q;
        if (s1_adv && in_valid) begin
            s1_sign_d    = in_sign;
            s1_exp_d     = in_exponent;
            s1_sum_d     = {1'b0, in_mantissa} + {24'd0, up};
            s1_inexact_d = inexact;
            s1_nan_d     = in_nan;
            s1_inf_d     = in_inf;
            s1_zero_d    = in_zero;
            s1_mode_d    = in_mode;
        end
    end

    // S2: resolve carry, overflow and specials into the final word
    always_comb begin
        logic [8:0]  e9;
        logic [22:0] frac;
        logic        to_inf;
        logic [31:0] res;
        logic [4:0]  flg;

        if (s1_sum_q[24]) begin
            e9   = {1'b0, s1_exp_q} + 9'd1;
            frac = s1_sum_q[23:1];
        end else if (s1_exp_q == 8'd0 && s1_sum_q[23]) begin
            e9   = 9'd1;
            frac = s1_sum_q[22:0];
        end else begin
            e9   = {1'b0, s1_exp_q};
            frac = s1_sum_q[22:0];
        end

        unique case (s1_mode_q)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = s1_sign_q;
            RM_RUP:  to_inf = !s1_sign_q;
            default: to_inf = 1'b1;
        endcase

        if (s1_zero_q) begin
            res = {s1_sign_q, 31'd0};
            flg = 5'b00000;
        end else if (s1_nan_q) begin
            res = 32'h7FC0_0000;
            flg = {s1_sign_q, 4'b0000};
        end else if (s1_inf_q) begin
            res = {s1_sign_q, 8'hFF, 23'd0};
            flg = 5'b00000;
        end else if (e9 >= 9'd255) begin
            res = to_inf ? {s1_sign_q, 8'hFF, 23'd0}
                         : {s1_sign_q, 8'hFE, 23'h7F_FFFF};
            flg = 5'b00101;
        end else begin
            res = {s1_sign_q, e9[7:0], frac};
            flg = {3'b000,
                   s1_inexact_q && (s1_exp_q == 8'd0),
                   s1_inexact_q};
        end

        s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        if (s2_adv && s1_valid_q) begin
            s2_result_d = res;
            s2_flags_d  = flg;
        end
    end

    // Pipeline registers; reset discards every in-flight beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= 8'd0;
            s1_sum_q     <= 25'd0;
            s1_inexact_q <= 1'b0;
            s1_nan_q     <= 1'b0;
            s1_inf_q     <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_mode_q    <= 3'd0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= 32'd0;
            s2_flags_q   <= 5'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_sum_q     <= s1_sum_d;
            s1_inexact_q <= s1_inexact_d;
            s1_nan_q     <= s1_nan_d;
            s1_inf_q     <= s1_inf_d;
            s1_zero_q    <= s1_zero_d;
            s1_mode_q    <= s1_mode_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_flags_q   <= s2_flags_d;
        end
    end

endmodule

// File: tb/tb_fpu_round_pack.sv
// tb_fpu_round_pack: directed steps feeding a scoreboard queue;
// a negedge monitor pops and compares every emitted beat.
module tb_fpu_round_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exponent = 8'd0;
    logic [23:0] in_mantissa = 24'd0;
    logic [2:0]  in_guard = 3'd0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic        in_zero = 1'b0;
    logic [2:0]  in_mode = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    int errors = 0;
    int checks = 0;
    int emitted = 0;
    logic [36:0] sb_q[$];

    fpu_round_pack dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exponent (in_exponent),
        .in_mantissa (in_mantissa),
        .in_guard    (in_guard),
        .in_nan      (in_nan),
        .in_inf      (in_inf),
        .in_zero     (in_zero),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [36:0] obs,
                       input logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: a beat transfers at the posedge after a negedge
    // where out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            emitted++;
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", {out_flags, out_result}, 37'h0);
                if ({out_flags, out_result} == 37'h0) begin
                    errors++;
                    $error("FAIL unexpected_beat observed=extra expected=none");
                end
            end else begin
                chk("beat", {out_flags, out_result}, sb_q.pop_front());
            end
        end
    end

    // Drive one beat, push its expectation, return #1 after acceptance
    task automatic send(input logic s, input logic [7:0] e,
                        input logic [23:0] m, input logic [2:0] g,
                        input logic [2:0] md, input logic [2:0] spc,
                        input logic [31:0] xr, input logic [4:0] xf);
        logic acc;
        int   n;
        in_valid    = 1'b1;
        in_sign     = s;
        in_exponent = e;
        in_mantissa = m;
        in_guard    = g;
        in_mode     = md;
        {in_nan, in_inf, in_zero} = spc;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb_q.push_back({xf, xr});
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout observed=stalled expected=accepted");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 37'(sb_q.size()), 37'd0);
    endtask

    initial begin
        #2;
        chk("rst_out_valid", 37'(out_valid), 37'd0);
        chk("rst_out_word", {out_flags, out_result}, 37'h0);
        chk("rst_in_ready", 37'(in_ready), 37'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: valid appears one edge after S1 capture,
        // and the beat transfers on the second edge after accept.
        send(0, 8'd128, 24'h800000, 3'b000, 3'd0, 3'b000,
             32'h4000_0000, 5'b00000);
        chk("lat_s1_only", 37'(out_valid), 37'd0);
        @(posedge clk);
        #1;
        chk("lat_out_valid", 37'(out_valid), 37'd1);
        drain();

        send(0, 8'd127, 24'h800000, 3'b100, 3'd0, 3'b000,
             32'h3F80_0000, 5'b00001);
        send(0, 8'd127, 24'h800000, 3'b100, 3'd4, 3'b000,
             32'h3F80_0001, 5'b00001);
        send(0, 8'd127, 24'hFFFFFF, 3'b100, 3'd0, 3'b000,
             32'h4000_0000, 5'b00001);
        send(0, 8'd254, 24'hFFFFFF, 3'b111, 3'd0, 3'b000,
             32'h7F80_0000, 5'b00101);
        send(0, 8'd254, 24'hFFFFFF, 3'b111, 3'd1, 3'b000,
             32'h7F7F_FFFF, 5'b00001);
        send(0, 8'd255, 24'h800000, 3'b000, 3'd1, 3'b000,
             32'h7F7F_FFFF, 5'b00101);
        send(1, 8'd254, 24'hFFFFFF, 3'b111, 3'd2, 3'b000,
             32'hFF80_0000, 5'b00101);
        send(1, 8'd5, 24'h800000, 3'b000, 3'd0, 3'b100,
             32'h7FC0_0000, 5'b10000);
        send(1, 8'd5, 24'h800000, 3'b111, 3'd0, 3'b001,
             32'h8000_0000, 5'b00000);
        send(0, 8'd9, 24'h123456, 3'b000, 3'd0, 3'b010,
             32'h7F80_0000, 5'b00000);
        send(0, 8'd0, 24'h7FFFFF, 3'b110, 3'd6, 3'b000,
             32'h0080_0000, 5'b00011);
        send(0, 8'd0, 24'h400000, 3'b001, 3'd1, 3'b000,
             32'h0040_0000, 5'b00011);
        drain();

        // Backpressure stream of 6 beats
        emitted = 0;
        out_ready = 1'b0;
        fork
            begin
                send(0, 8'd128, 24'h800000, 3'b000, 3'd0, 3'b000,
                     32'h4000_0000, 5'b00000);
                send(0, 8'd129, 24'hC00000, 3'b000, 3'd0, 3'b000,
                     32'h40C0_0000, 5'b00000);
                send(1, 8'd127, 24'h800000, 3'b001, 3'd3, 3'b000,
                     32'hBF80_0000, 5'b00001);
                send(1, 8'd127, 24'h800000, 3'b001, 3'd2, 3'b000,
                     32'hBF80_0001, 5'b00001);
                send(0, 8'd127, 24'h800001, 3'b100, 3'd0, 3'b000,
                     32'h3F80_0002, 5'b00001);
                send(0, 8'd3, 24'h800000, 3'b000, 3'd0, 3'b001,
                     32'h0000_0000, 5'b00000);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", 37'(in_ready), 37'd0);
                chk("bp_out_valid", 37'(out_valid), 37'd1);
                chk("bp_buffered", 37'(sb_q.size()), 37'd2);
                @(posedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        @(posedge clk);
        #1;
        chk("bp_emitted_once", 37'(emitted), 37'd6);

        // Reset with both stages holding a beat
        out_ready = 1'b0;
        send(0, 8'd130, 24'h800000, 3'b000, 3'd0, 3'b000,
             32'h4100_0000, 5'b00000);
        send(0, 8'd131, 24'h800000, 3'b000, 3'd0, 3'b000,
             32'h4180_0000, 5'b00000);
        chk("pre_rst_full", {35'd0, out_valid, in_ready}, 37'b10);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("mid_rst_out_valid", 37'(out_valid), 37'd0);
        chk("mid_rst_out_word", {out_flags, out_result}, 37'h0);
        chk("mid_rst_in_ready", 37'(in_ready), 37'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        emitted = 0;
        send(0, 8'd126, 24'hFFFFFF, 3'b100, 3'd0, 3'b000,
             32'h3F80_0000, 5'b00001);
        chk("post_rst_s1_only", 37'(out_valid), 37'd0);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 37'(out_valid), 37'd1);
        drain();
        @(posedge clk);
        #1;
        chk("post_rst_emitted", 37'(emitted), 37'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
